// File: rtl/dram_arb_pkg.sv
// Shared constants for the DRAM read-port arbiter: default DRAM address/data
// widths, requester index assignments and a constant-safe clog2 helper.
package dram_arb_pkg;

    localparam int DRAM_ADDR_W = 25;
    localparam int DRAM_DATA_W = 256;

    // Requester slots on the shared read port.
    localparam int REQ_TRIG = 0;  // trigger readout address generator
    localparam int REQ_HOST = 1;  // host debug / readback

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Synchronous tag FIFO holding the requester index of every read in flight.
// Head entry is visible combinationally so a return can be routed in the
// same cycle it pops. Push and pop may occur together when non-empty.
module arb_tag_fifo
    import dram_arb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr_q[PTR_W-1:0]];

    // Pointer advance; overflow/underflow requests are ignored.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Tag storage write port.
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter sharing the single DRAM read port between NUM_REQ
// requesters. Reads are credit-limited to MAX_OUTSTANDING in flight; return
// data comes back in issue order and is routed by a tag FIFO.
// Optional build macro: DRAM_ARB_STATS_EN adds per-requester grant counters.
module dram_read_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = DRAM_ADDR_W,
    parameter int DATA_W          = DRAM_DATA_W,
    parameter int MAX_OUTSTANDING = 16,
    parameter int STAT_W          = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]           req_addr,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                DRAM_Read_Enable,
    output logic [ADDR_W-1:0]                   DRAM_Read_Addr,
    input  logic [DATA_W-1:0]                   DRAM_Read_Data,
    input  logic                                DRAM_Read_Valid,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_W-1:0]                   rsp_data,
    output logic [clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                orphan_err
`ifdef DRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]           grant_cnt
`endif
);

    localparam int TAG_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic                 read_en_q,     read_en_d;
    logic [ADDR_W-1:0]    read_addr_q,   read_addr_d;
    logic [TAG_W-1:0]     rr_ptr_q,      rr_ptr_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;
    logic [NUM_REQ-1:0]   rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q,    rsp_data_d;
    logic                 orphan_q,      orphan_d;
`ifdef DRAM_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] grant_cnt_q, grant_cnt_d;
`endif

    logic                 grant_any;
    logic [TAG_W-1:0]     grant_idx;
    logic                 pop_ok;
    logic [TAG_W-1:0]     head_tag;
    logic                 fifo_empty;
    logic                 fifo_full;

    // Round-robin pick: lowest valid index at or after rr_ptr, wrapping.
    // outstanding_q already includes every earlier grant, and a return in this
    // cycle is deliberately not credited until the next cycle.
    // NOTE: every combinational output gets a default first so no latch is inferred on any path.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (rst && (outstanding_q < MAX_CNT) && !fifo_full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = TAG_W'(idx);
                end
            end
        end
    end

    // One-hot grant to the selected requester.
    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_any),
        .push_data (grant_idx),
        .pop       (DRAM_Read_Valid),
        .pop_data  (head_tag),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Next-state for issue strobe, credit counter, response demux and orphan flag.
    always_comb begin
        pop_ok      = DRAM_Read_Valid && !fifo_empty;
        read_en_d   = grant_any;
        read_addr_d = grant_any ? req_addr[int'(grant_idx)*ADDR_W +: ADDR_W] : read_addr_q;

        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end

        case ({grant_any, pop_ok})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        rsp_valid_d = '0;
        if (pop_ok) begin
            rsp_valid_d[head_tag] = 1'b1;
        end
        rsp_data_d = pop_ok ? DRAM_Read_Data : rsp_data_q;

        orphan_d = orphan_q || (DRAM_Read_Valid && fifo_empty);

`ifdef DRAM_ARB_STATS_EN
        grant_cnt_d = grant_cnt_q;
        if (grant_any) begin
            grant_cnt_d[int'(grant_idx)*STAT_W +: STAT_W] =
                grant_cnt_q[int'(grant_idx)*STAT_W +: STAT_W] + 1'b1;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            read_en_q     <= 1'b0;
            read_addr_q   <= '0;
            rr_ptr_q      <= TAG_W'(REQ_TRIG);
            outstanding_q <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            orphan_q      <= 1'b0;
`ifdef DRAM_ARB_STATS_EN
            grant_cnt_q   <= '0;
`endif
        end else begin
            read_en_q     <= read_en_d;
            read_addr_q   <= read_addr_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            orphan_q      <= orphan_d;
`ifdef DRAM_ARB_STATS_EN
            grant_cnt_q   <= grant_cnt_d;
`endif
        end
    end

    assign DRAM_Read_Enable = read_en_q;
    assign DRAM_Read_Addr   = read_addr_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign outstanding      = outstanding_q;
    assign orphan_err       = orphan_q;
`ifdef DRAM_ARB_STATS_EN
    assign grant_cnt        = grant_cnt_q;
`endif

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Directed bench for dram_read_arbiter (default parameters: 2 requesters,
// 25-bit address, 256-bit data, 16 credits). Grant-counter checks are built
// only when DRAM_ARB_STATS_EN is defined.
module tb_dram_read_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [49:0]  req_addr;
    logic [1:0]   req_ready;
    logic         DRAM_Read_Enable;
    logic [24:0]  DRAM_Read_Addr;
    logic [255:0] DRAM_Read_Data;
    logic         DRAM_Read_Valid;
    logic [1:0]   rsp_valid;
    logic [255:0] rsp_data;
    logic [4:0]   outstanding;
    logic         orphan_err;
`ifdef DRAM_ARB_STATS_EN
    logic [63:0]  grant_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int strobes;

    dram_read_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_ready        (req_ready),
        .DRAM_Read_Enable (DRAM_Read_Enable),
        .DRAM_Read_Addr   (DRAM_Read_Addr),
        .DRAM_Read_Data   (DRAM_Read_Data),
        .DRAM_Read_Valid  (DRAM_Read_Valid),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .outstanding      (outstanding),
        .orphan_err       (orphan_err)
`ifdef DRAM_ARB_STATS_EN
        ,
        .grant_cnt        (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and registered outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mkdata(input int k);
        return {8{32'hD00D_0000 + 32'(k)}};
    endfunction

    initial begin
        rst             = 1'b0;
        req_valid       = 2'b11;
        req_addr        = '0;
        DRAM_Read_Data  = '0;
        DRAM_Read_Valid = 1'b0;

        // Reset state; requests present during reset must not be granted.
        repeat (3) step();
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_enable", DRAM_Read_Enable, 1'b0);
        check("rst_addr", DRAM_Read_Addr, 25'h0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_data", rsp_data, 256'h0);
        check("rst_outstanding", outstanding, 5'd0);
        check("rst_orphan", orphan_err, 1'b0);

        req_valid = 2'b00;
        rst = 1'b1;
        repeat (2) step();

        // Single request from requester 0.
        req_valid = 2'b01;
        req_addr[24:0] = 25'h0123456;
        #1;
        check("single_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("single_enable", DRAM_Read_Enable, 1'b1);
        check("single_addr", DRAM_Read_Addr, 25'h0123456);
        check("single_outstanding", outstanding, 5'd1);
        step();
        check("single_enable_drop", DRAM_Read_Enable, 1'b0);
        check("single_addr_hold", DRAM_Read_Addr, 25'h0123456);

        // Its return goes to requester 0, one cycle after DRAM_Read_Valid.
        DRAM_Read_Valid = 1'b1;
        DRAM_Read_Data  = mkdata(100);
        step();
        DRAM_Read_Valid = 1'b0;
        check("single_rsp_valid", rsp_valid, 2'b01);
        check("single_rsp_data", rsp_data, mkdata(100));
        check("single_outstanding_ret", outstanding, 5'd0);
        step();
        check("single_rsp_pulse", rsp_valid, 2'b00);

        // Both requesters valid: rr pointer sits at 1, so grants go 1,0,1,0.
        req_addr = {25'h1AAAAAA, 25'h0555555};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_ready", req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
            step();
            check("alt_enable", DRAM_Read_Enable, 1'b1);
            check("alt_addr", DRAM_Read_Addr, (i % 2 == 0) ? 25'h1AAAAAA : 25'h0555555);
        end
        req_valid = 2'b00;
        step();
        check("alt_enable_drop", DRAM_Read_Enable, 1'b0);
        check("alt_outstanding", outstanding, 5'd4);

        // Returns come back in issue order with an idle cycle between them.
        for (int i = 0; i < 4; i++) begin
            DRAM_Read_Valid = 1'b1;
            DRAM_Read_Data  = mkdata(i);
            step();
            DRAM_Read_Valid = 1'b0;
            check("ret_rsp_valid", rsp_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
            check("ret_rsp_data", rsp_data, mkdata(i));
            step();
            check("ret_rsp_pulse", rsp_valid, 2'b00);
        end
        check("ret_outstanding", outstanding, 5'd0);

        // Credit limit: requester 0 always valid, no returns -> exactly 16 strobes.
        req_addr[24:0] = 25'h0000ABC;
        req_valid = 2'b01;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (DRAM_Read_Enable) strobes++;
        end
        check("credit_strobes", 32'(strobes), 32'd16);
        check("credit_outstanding", outstanding, 5'd16);
        check("credit_ready_blocked", req_ready, 2'b00);

        // A return does not free credit in its own cycle.
        DRAM_Read_Valid = 1'b1;
        DRAM_Read_Data  = mkdata(200);
        #1;
        check("credit_no_early", req_ready, 2'b00);
        step();
        DRAM_Read_Valid = 1'b0;
        check("credit_ret_rsp", rsp_valid, 2'b01);
        check("credit_ret_outstanding", outstanding, 5'd15);
        check("credit_ret_enable", DRAM_Read_Enable, 1'b0);
        #1;
        check("credit_regrant", req_ready, 2'b01);
        step();
        check("credit_regrant_enable", DRAM_Read_Enable, 1'b1);
        check("credit_refull", outstanding, 5'd16);
        #1;
        check("credit_reblocked", req_ready, 2'b00);
        req_valid = 2'b00;

        // Drain all 16.
        DRAM_Read_Valid = 1'b1;
        repeat (16) step();
        DRAM_Read_Valid = 1'b0;
        check("drain_outstanding", outstanding, 5'd0);
        check("drain_orphan", orphan_err, 1'b0);

        // Grant and return in the same cycle leave outstanding unchanged.
        req_valid = 2'b10;
        #1;
        check("same_ready", req_ready, 2'b10);
        step();
        check("same_outstanding_1", outstanding, 5'd1);
        DRAM_Read_Valid = 1'b1;
        DRAM_Read_Data  = mkdata(300);
        #1;
        check("same_ready_2", req_ready, 2'b10);
        step();
        check("same_outstanding_hold", outstanding, 5'd1);
        check("same_rsp_valid", rsp_valid, 2'b10);
        check("same_enable", DRAM_Read_Enable, 1'b1);
        req_valid = 2'b00;
        DRAM_Read_Data = mkdata(301);
        step();
        DRAM_Read_Valid = 1'b0;
        check("same_outstanding_0", outstanding, 5'd0);
        check("same_rsp_data", rsp_data, mkdata(301));

        // Orphan return: dropped, sticky error, rsp_data holds.
        DRAM_Read_Valid = 1'b1;
        DRAM_Read_Data  = mkdata(400);
        step();
        DRAM_Read_Valid = 1'b0;
        check("orphan_rsp_valid", rsp_valid, 2'b00);
        check("orphan_flag", orphan_err, 1'b1);
        check("orphan_data_hold", rsp_data, mkdata(301));
        check("orphan_outstanding", outstanding, 5'd0);
        repeat (3) step();
        check("orphan_sticky", orphan_err, 1'b1);

        // Reset mid-operation discards in-flight tags.
        req_valid = 2'b01;
        repeat (2) step();
        check("midrst_outstanding_pre", outstanding, 5'd2);
        req_valid = 2'b00;
        rst = 1'b0;
        step();
        check("midrst_outstanding", outstanding, 5'd0);
        check("midrst_orphan_clr", orphan_err, 1'b0);
        check("midrst_enable", DRAM_Read_Enable, 1'b0);
        check("midrst_addr", DRAM_Read_Addr, 25'h0);
        rst = 1'b1;
        step();
        DRAM_Read_Valid = 1'b1;
        DRAM_Read_Data  = mkdata(500);
        step();
        DRAM_Read_Valid = 1'b0;
        check("postrst_rsp_valid", rsp_valid, 2'b00);
        check("postrst_orphan", orphan_err, 1'b1);
        check("postrst_outstanding", outstanding, 5'd0);

`ifdef DRAM_ARB_STATS_EN
        // Grant counters: 10 grants to requester 0, 7 to requester 1.
        rst = 1'b0;
        step();
        check("stats_rst", grant_cnt, 64'h0);
        rst = 1'b1;
        step();
        req_valid = 2'b11;
        repeat (14) step();
        req_valid = 2'b00;
        DRAM_Read_Valid = 1'b1;
        repeat (14) step();
        DRAM_Read_Valid = 1'b0;
        req_valid = 2'b01;
        repeat (3) step();
        req_valid = 2'b00;
        step();
        check("stats_counts", grant_cnt, {32'd7, 32'd10});
        rst = 1'b0;
        step();
        check("stats_clear", grant_cnt, 64'h0);
        rst = 1'b1;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
